counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Front-end controller for the loadable state counter on the DE2 lab board. It turns the load, step and run/pause pushbuttons into clean one-cycle strobes, and auto-steps the counter from a prescaled CLOCK_50 tick. It also counts steps since the last load, with an optional run length. Its outputs drive the counter's load/clock-enable inputs; step_count feeds the binary-to-BCD display path.

Parameters:
TICK_DIV, 50000000, base auto-step period in CLOCK_50 cycles (1 Hz).
DIV_W, 26, prescaler width; must hold TICK_DIV-1.
DEB_CYCLES, 500000, consecutive stable samples needed to accept a key level (10 ms).
SYNC_STAGES, 2, synchronizer flops per key input.

Ports:
CLOCK_50  in  1  single system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
key_load_n  in  1  load pushbutton, active-low, asynchronous, bouncy
key_step_n  in  1  single-step pushbutton, active-low
key_run_n  in  1  run/pause toggle pushbutton, active-low
load_val  in  3  value to load into the counter
run_len  in  8  auto-steps per run; 0 = unlimited
div_sel  in  2  tick period = TICK_DIV >> (2*div_sel)
cnt_load  out  1  one-cycle load strobe
cnt_d  out  3  load data, held stable from the load strobe onward
cnt_step  out  1  one-cycle step strobe (counter clock enable)
step_count  out  8  steps since last load, wraps 255->0
state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
done  out  1  one-cycle pulse when a limited run completes

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, prescaler 0, remaining 0, every debouncer in the "released" state.
- Key path: SYNC_STAGES-flop synchronizer, then a debouncer.
  - Debounced level changes only after DEB_CYCLES consecutive equal synchronized samples.
  - A press event is a released->pressed transition of the debounced level, one cycle wide.
  - Release generates nothing.
  - A key held through reset produces one event after debounce.
- Event-to-strobe latency is constant and at most SYNC_STAGES+DEB_CYCLES+2 cycles. All outputs are registered.
- Priority for same-cycle events: load > run > step > tick.
- Prescaler:
  - Counts only in RUN.
  - tick fires when count == period-1, then wraps to 0.
  - Cleared on entering RUN from IDLE or DONE. Held (not cleared) in PAUSE.
  - If div_sel lowers the period below the current count, tick fires next cycle and wraps.
- Any step (manual or tick): cnt_step=1 for one cycle and step_count+1 mod 256.
- Any load event, in every state:
  - cnt_load=1 for one cycle and cnt_d<=load_val in the same cycle.
  - step_count<=0 and state<=IDLE.
- IDLE: step event -> step. Run event -> RUN, remaining<=run_len.
- RUN:
  - tick -> step. If run_len at entry was non-zero, remaining-1; on reaching 0 go to DONE.
  - Run event -> PAUSE; a coincident tick is dropped.
  - Step events are ignored.
- PAUSE:
  - Run event -> RUN, prescaler resumes.
  - Step event -> step, counted against remaining; may complete the run -> DONE.
- DONE:
  - done=1 in the first cycle in DONE, i.e. the cycle after the final cnt_step.
  - Run event -> RUN with fresh remaining<=run_len. Step events are ignored.
- run_len is sampled only on entering RUN from IDLE or DONE; later changes do not affect the current run.
- Async reset mid-run: strobes drop immediately and no strobe is emitted on release.

Test Plan:
(bench: TICK_DIV=16, DEB_CYCLES=4, SYNC_STAGES=2)
1. Reset, load_val=5, press load -> exactly one cnt_load pulse, cnt_d=5, step_count=0, state=0.
2. In IDLE, press step 3 times -> 3 single-cycle cnt_step pulses, step_count=3, state stays 0.
3. run_len=4, div_sel=0, press run -> state=1, 4 cnt_step pulses exactly 16 cycles apart. Cycle after the 4th: state=3 and done=1 for one cycle. Then press step -> no pulse.
4. run_len=0, div_sel=1 (period 4), press run, let step_count pass 255 -> wraps to 0. Press run -> state=2, no pulses for 100 cycles. Press step -> one pulse. Press run -> pulses resume, the first coming 4-(held prescaler count) cycles later.
5. key_step_n toggles every 2 cycles for 20 cycles, then holds low 10 cycles, then toggles again on release -> exactly one cnt_step.
6. Assert reset mid-RUN between ticks -> all outputs 0 asynchronously, state=0. No cnt_step after release for 40 cycles.

Source files
------------

// File: rtl/counter_sequencer.sv
// Pushbutton front end for the DE2 loadable counter: debounced key strobes,
// prescaled auto-stepping and a steps-since-load counter with optional run length.
module counter_sequencer #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_load_n,
    input  logic       key_step_n,
    input  logic       key_run_n,
    input  logic [2:0] load_val,
    input  logic [7:0] run_len,
    input  logic [1:0] div_sel,
    output logic       cnt_load,
    output logic [2:0] cnt_d,
    output logic       cnt_step,
    output logic [7:0] step_count,
    output logic [1:0] state,
    output logic       done
);

    localparam int unsigned NKEYS = 3;
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_BASE = DIV_W'(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [NKEYS-1:0]       keys_c;
    logic [SYNC_STAGES-1:0] sync_q [NKEYS];
    logic [DEB_W-1:0]       deb_q  [NKEYS];
    logic [NKEYS-1:0]       level_q;
    logic [NKEYS-1:0]       press_q;

    logic ev_load, ev_run, ev_step;

    state_t           state_q, state_nx;
    logic [DIV_W-1:0] pre_q, pre_nx;
    logic [DIV_W-1:0] shifted_c, period_c;
    logic [7:0]       rem_q, rem_nx;
    logic             lim_q, lim_nx;
    logic [7:0]       count_nx;
    logic [2:0]       d_nx;
    logic             load_nx, step_nx, done_nx;
    logic             tick_c, do_step_c;

    // key index: 0 load, 1 run, 2 step (all active-low)
    assign keys_c = {key_step_n, key_run_n, key_load_n};

    // Synchronizer plus debouncer; a press is a released->pressed change of the debounced level
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NKEYS; i++) begin
                sync_q[i] <= '1;
                deb_q[i]  <= '0;
            end
            level_q <= '1;
            press_q <= '0;
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                sync_q[i]  <= (sync_q[i] << 1) | SYNC_STAGES'(keys_c[i]);
                press_q[i] <= 1'b0;
                if (sync_q[i][SYNC_STAGES-1] == level_q[i]) begin
                    deb_q[i] <= '0;
                end else if (deb_q[i] == DEB_LAST) begin
                    level_q[i] <= sync_q[i][SYNC_STAGES-1];
                    deb_q[i]   <= '0;
                    press_q[i] <= ~sync_q[i][SYNC_STAGES-1];
                end else begin
                    deb_q[i] <= deb_q[i] + DEB_W'(1);
                end
            end
        end
    end

    assign ev_load = press_q[0];
    assign ev_run  = press_q[1];
    assign ev_step = press_q[2];

    // A period that shifts down to zero is treated as one tick per cycle
    assign shifted_c = DIV_BASE >> {div_sel, 1'b0};
    assign period_c  = (shifted_c == '0) ? DIV_W'(1) : shifted_c;
    assign tick_c    = (state_q == RUN) && (pre_q >= period_c - DIV_W'(1));

    assign state = state_q;

    // A limited run that has used up its steps finishes one cycle after its last step
    always_comb begin
        state_nx  = state_q;
        pre_nx    = pre_q;
        rem_nx    = rem_q;
        lim_nx    = lim_q;
        count_nx  = step_count;
        d_nx      = cnt_d;
        load_nx   = 1'b0;
        step_nx   = 1'b0;
        done_nx   = 1'b0;
        do_step_c = 1'b0;

        if (state_q == RUN) begin
            pre_nx = tick_c ? '0 : pre_q + DIV_W'(1);
        end

        if (ev_load) begin
            load_nx  = 1'b1;
            d_nx     = load_val;
            count_nx = '0;
            state_nx = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev_run) begin
                        state_nx = RUN;
                        pre_nx   = '0;
                        rem_nx   = run_len;
                        lim_nx   = |run_len;
                    end else if (ev_step) begin
                        do_step_c = 1'b1;
                    end
                end
                RUN: begin
                    if (lim_q && (rem_q == '0)) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else if (ev_run) begin
                        state_nx = PAUSE;
                    end else if (tick_c) begin
                        do_step_c = 1'b1;
                        if (lim_q) rem_nx = rem_q - 8'd1;
                    end
                end
                PAUSE: begin
                    if (lim_q && (rem_q == '0)) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else if (ev_run) begin
                        state_nx = RUN;
                    end else if (ev_step) begin
                        do_step_c = 1'b1;
                        if (lim_q) rem_nx = rem_q - 8'd1;
                    end
                end
                DONE: begin
                    if (ev_run) begin
                        state_nx = RUN;
                        pre_nx   = '0;
                        rem_nx   = run_len;
                        lim_nx   = |run_len;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        if (do_step_c) begin
            step_nx  = 1'b1;
            count_nx = step_count + 8'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            rem_q      <= '0;
            lim_q      <= 1'b0;
            cnt_load   <= 1'b0;
            cnt_d      <= '0;
            cnt_step   <= 1'b0;
            step_count <= '0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_nx;
            pre_q      <= pre_nx;
            rem_q      <= rem_nx;
            lim_q      <= lim_nx;
            cnt_load   <= load_nx;
            cnt_d      <= d_nx;
            cnt_step   <= step_nx;
            step_count <= count_nx;
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: table of key actions, hand-built corner sequences and
// random key activity, all compared every cycle against a behavioural model.
module tb_counter_sequencer;

    localparam int TB_TICK = 16;
    localparam int TB_DEB  = 4;
    localparam int TB_SYNC = 2;
    localparam int HIST    = TB_SYNC + TB_DEB;

    localparam int K_NONE = 0;
    localparam int K_LOAD = 1;
    localparam int K_RUN  = 2;
    localparam int K_STEP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_load_n = 1'b1;
    logic       key_step_n = 1'b1;
    logic       key_run_n  = 1'b1;
    logic [2:0] load_val = '0;
    logic [7:0] run_len  = '0;
    logic [1:0] div_sel  = '0;

    logic       cnt_load, cnt_step, done;
    logic [2:0] cnt_d;
    logic [7:0] step_count;
    logic [1:0] state;
    logic [15:0] dut_vec;

    counter_sequencer #(
        .TICK_DIV(TB_TICK), .DIV_W(5), .DEB_CYCLES(TB_DEB), .SYNC_STAGES(TB_SYNC)
    ) dut (
        .CLOCK_50(clk), .reset(rst),
        .key_load_n(key_load_n), .key_step_n(key_step_n), .key_run_n(key_run_n),
        .load_val(load_val), .run_len(run_len), .div_sel(div_sel),
        .cnt_load(cnt_load), .cnt_d(cnt_d), .cnt_step(cnt_step),
        .step_count(step_count), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    assign dut_vec = {cnt_load, cnt_d, cnt_step, step_count, state, done};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int step_edges[$];
    int done_edges[$];

    // Behavioural model: states 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE; m_left = -1 means unlimited
    int m_state, m_cnt, m_pre, m_left, m_d;
    bit m_load, m_step, m_done;
    bit k_raw [3][HIST];
    bit k_lev [3];
    bit k_pend[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_cnt = 0; m_pre = 0; m_left = -1; m_d = 0;
        m_load = 0; m_step = 0; m_done = 0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < HIST; j++) k_raw[k][j] = 1'b1;
            k_lev[k]  = 1'b1;
            k_pend[k] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        int period;
        int pre_next;
        bit tick;
        bit stepping;
        bit now_k[3];
        bit all0;
        bit all1;

        period = TB_TICK >> (2 * int'(div_sel));
        if (period < 1) period = 1;
        tick     = (m_state == 1) && (m_pre >= period - 1);
        pre_next = m_pre;
        if (m_state == 1) pre_next = tick ? 0 : m_pre + 1;
        m_load = 0; m_step = 0; m_done = 0; stepping = 0;

        if (k_pend[0]) begin
            m_load = 1; m_d = int'(load_val); m_cnt = 0; m_state = 0;
        end else begin
            case (m_state)
                0: if (k_pend[1]) begin
                       m_state = 1; pre_next = 0;
                       m_left = (run_len == 0) ? -1 : int'(run_len);
                   end else if (k_pend[2]) stepping = 1;
                1: if (m_left == 0) begin m_state = 3; m_done = 1; end
                   else if (k_pend[1]) m_state = 2;
                   else if (tick) begin stepping = 1; if (m_left > 0) m_left--; end
                2: if (m_left == 0) begin m_state = 3; m_done = 1; end
                   else if (k_pend[1]) m_state = 1;
                   else if (k_pend[2]) begin stepping = 1; if (m_left > 0) m_left--; end
                default: if (k_pend[1]) begin
                       m_state = 1; pre_next = 0;
                       m_left = (run_len == 0) ? -1 : int'(run_len);
                   end
            endcase
        end
        m_pre = pre_next;
        if (stepping) begin m_step = 1; m_cnt = (m_cnt + 1) % 256; end

        // Key path: a level is accepted once the last TB_DEB synchronized samples agree
        now_k[0] = key_load_n; now_k[1] = key_run_n; now_k[2] = key_step_n;
        for (int k = 0; k < 3; k++) begin
            for (int j = HIST - 1; j > 0; j--) k_raw[k][j] = k_raw[k][j-1];
            k_raw[k][0] = now_k[k];
            all0 = 1; all1 = 1;
            for (int j = TB_SYNC; j < HIST; j++) begin
                if (k_raw[k][j]) all0 = 0; else all1 = 0;
            end
            k_pend[k] = 0;
            if (k_lev[k] && all0) begin k_lev[k] = 0; k_pend[k] = 1; end
            else if (!k_lev[k] && all1) k_lev[k] = 1;
        end
    endfunction

    task automatic cycle();
        logic [15:0] mv;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) model_reset(); else model_step();
        mv = {m_load, 3'(m_d), m_step, 8'(m_cnt), 2'(m_state), m_done};
        check("lockstep", 32'(dut_vec), 32'(mv));
        if (cnt_step) step_edges.push_back(cyc);
        if (done) done_edges.push_back(cyc);
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_LOAD:  key_load_n = v;
            K_RUN:   key_run_n  = v;
            K_STEP:  key_step_n = v;
            default: ;
        endcase
    endtask

    task automatic press(input int k);
        set_key(k, 1'b0);
        repeat (10) cycle();
        set_key(k, 1'b1);
        repeat (10) cycle();
    endtask

    typedef struct {
        int key; int lval; int rlen; int dsel; int wait_n;
        int exp_state; int exp_cnt; int exp_d;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int found, n0, h, run_e, step_e;

        tbl[0] = '{K_LOAD, 5, 0, 0, 0,  0, 0, 5};
        tbl[1] = '{K_STEP, 5, 0, 0, 0,  0, 1, 5};
        tbl[2] = '{K_STEP, 5, 0, 0, 0,  0, 2, 5};
        tbl[3] = '{K_STEP, 5, 0, 0, 0,  0, 3, 5};
        tbl[4] = '{K_RUN,  5, 4, 0, 0,  1, 3, 5};
        tbl[5] = '{K_NONE, 5, 4, 0, 80, 3, 7, 5};
        tbl[6] = '{K_STEP, 5, 4, 0, 0,  3, 7, 5};
        tbl[7] = '{K_LOAD, 2, 4, 0, 0,  0, 0, 2};

        model_reset();
        repeat (3) cycle();
        check("reset_state", 32'(dut_vec), 32'd0);
        rst = 1'b0;
        step_edges.delete();
        done_edges.delete();

        for (int i = 0; i < 8; i++) begin
            load_val = 3'(tbl[i].lval);
            run_len  = 8'(tbl[i].rlen);
            div_sel  = 2'(tbl[i].dsel);
            if (tbl[i].key != K_NONE) press(tbl[i].key);
            repeat (tbl[i].wait_n) cycle();
            check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
            check($sformatf("vec%0d_count", i), 32'(step_count), 32'(tbl[i].exp_cnt));
            check($sformatf("vec%0d_d", i), 32'(cnt_d), 32'(tbl[i].exp_d));
        end

        check("run_step_total", 32'(step_edges.size()), 32'd7);
        if (step_edges.size() == 7) begin
            for (int j = 4; j < 7; j++)
                check("tick_spacing", 32'(step_edges[j] - step_edges[j-1]), 32'(TB_TICK));
        end
        check("done_pulses", 32'(done_edges.size()), 32'd1);
        if (done_edges.size() == 1 && step_edges.size() == 7)
            check("done_timing", 32'(done_edges[0]), 32'(step_edges[6] + 1));

        // Unlimited run at period 4 through the 255 -> 0 wrap, then pause/step/resume
        run_len = 8'd0;
        div_sel = 2'd1;
        press(K_RUN);
        found = 0;
        for (int i = 0; i < 1500 && found == 0; i++) begin
            cycle();
            if (step_count == 8'd255) found = 1;
        end
        check("reach_255", 32'(found), 32'd1);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            cycle();
            if (cnt_step) found = 1;
        end
        check("wrap_step_seen", 32'(found), 32'd1);
        check("wrap_to_0", 32'(step_count), 32'd0);

        press(K_RUN);
        check("pause_state", 32'(state), 32'd2);
        n0 = step_edges.size();
        repeat (100) cycle();
        check("pause_quiet", 32'(step_edges.size() - n0), 32'd0);
        n0 = step_edges.size();
        press(K_STEP);
        check("pause_step", 32'(step_edges.size() - n0), 32'd1);

        h = m_pre;
        run_e = -1;
        step_e = -1;
        key_run_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) key_run_n = 1'b1;
            cycle();
            if (run_e < 0 && state == 2'd1) run_e = cyc;
            else if (run_e >= 0 && step_e < 0 && cnt_step) step_e = cyc;
        end
        check("resume_delay", 32'(step_e - run_e), 32'(4 - h));

        // Bouncing step key: only the settled press counts
        press(K_LOAD);
        n0 = step_edges.size();
        for (int i = 0; i < 20; i++) begin
            key_step_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        key_step_n = 1'b0;
        repeat (10) cycle();
        for (int i = 0; i < 20; i++) begin
            key_step_n = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            cycle();
        end
        key_step_n = 1'b1;
        repeat (20) cycle();
        check("bounce_one_step", 32'(step_edges.size() - n0), 32'd1);
        check("bounce_count", 32'(step_count), 32'd1);

        // Asynchronous reset between ticks of a run
        run_len = 8'd0;
        div_sel = 2'd0;
        press(K_RUN);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            cycle();
            if (cnt_step) found = 1;
        end
        check("pre_reset_tick", 32'(found), 32'd1);
        repeat (5) cycle();
        check("pre_reset_run", 32'(state), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", 32'(dut_vec), 32'd0);
        repeat (3) cycle();
        rst = 1'b0;
        n0 = step_edges.size();
        repeat (40) cycle();
        check("post_reset_quiet", 32'(step_edges.size() - n0), 32'd0);
        check("post_reset_state", 32'(state), 32'd0);

        // Random key activity, including short bounces and simultaneous presses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) key_load_n = ~key_load_n;
            if ($urandom_range(0, 5) == 0)  key_run_n  = ~key_run_n;
            if ($urandom_range(0, 4) == 0)  key_step_n = ~key_step_n;
            if ($urandom_range(0, 59) == 0) load_val = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) run_len  = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 59) == 0) div_sel  = 2'($urandom_range(0, 3));
            cycle();
        end
        key_load_n = 1'b1;
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        repeat (20) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
